// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the MEM-stage data cache controller:
//   - controller state encoding (IDLE / WB / RF)
//   - field widths of a byte address: tag | index | word offset | byte offset
//   - helpers to split a CPU address and to build a line-aligned address
// Default geometry: 32-bit addresses, 16 lines of 256 bits (8 words).
// ----------------------------------------------------------------------------
package dcache_pkg;

  localparam int DC_ADDR_W = 32;
  localparam int DC_IDX_W  = 4;
  localparam int DC_LINE_W = 256;
  localparam int OFF_W     = 5;
  localparam int WOFF_W    = 3;
  localparam int TAG_W     = DC_ADDR_W - DC_IDX_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RF   = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [DC_IDX_W-1:0] idx;
    logic [WOFF_W-1:0]   word;
    logic [1:0]          byteOff;
  } addr_fields_t;

  function automatic addr_fields_t splitAddr(input logic [DC_ADDR_W-1:0] addr);
    return addr_fields_t'(addr);
  endfunction

  // Line-aligned address: the low OFF_W bits are always zero.
  function automatic logic [DC_ADDR_W-1:0] lineAddr(input logic [TAG_W-1:0]    tag,
                                                    input logic [DC_IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// ----------------------------------------------------------------------------
// dcache_sram
// Storage for the direct-mapped data cache: per-line tag, valid, dirty and
// line data. Reads are asynchronous, writes happen on the rising clock edge.
// A line write (refill) loads tag and data, sets valid and clears dirty.
// A word write (store hit) updates one 32-bit word and sets dirty.
// Valid and dirty bits clear asynchronously on rst_i; tags and data do not
// need a reset because they are meaningless while valid is low.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   i_idx                   line index for both read and write
//   i_lineWe/i_lineTag/i_lineData   refill write
//   i_wordWe/i_wordSel/i_wordData   store-hit word write
//   o_tag/o_valid/o_dirty/o_line    contents of line i_idx
// ----------------------------------------------------------------------------
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int IDX_W    = DC_IDX_W,
  parameter int LINE_W   = DC_LINE_W,
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic                i_lineWe,
  input  logic [TAG_BITS-1:0] i_lineTag,
  input  logic [LINE_W-1:0]   i_lineData,
  input  logic                i_wordWe,
  input  logic [WOFF_W-1:0]   i_wordSel,
  input  logic [31:0]         i_wordData,
  output logic [TAG_BITS-1:0] o_tag,
  output logic                o_valid,
  output logic                o_dirty,
  output logic [LINE_W-1:0]   o_line
);

  localparam int Depth = 1 << IDX_W;

  logic [Depth-1:0]    r_valid;
  logic [Depth-1:0]    r_dirty;
  logic [TAG_BITS-1:0] r_tag  [Depth];
  logic [LINE_W-1:0]   r_data [Depth];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  // Line status bits. A refill always leaves the line clean; a store hit
  // marks it dirty. The two enables are never active together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_lineWe) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_wordWe) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (i_lineWe) begin
      r_tag[i_idx]  <= i_lineTag;
      r_data[i_idx] <= i_lineData;
    end else if (i_wordWe) begin
      r_data[i_idx][{i_wordSel, 5'b00000} +: 32] <= i_wordData;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl
// MEM-stage data cache: direct-mapped, write-back, write-allocate.
// Hits are served with zero latency in IDLE. A miss stalls the pipeline,
// optionally writes the dirty victim back (WB), then refills the line (RF)
// and returns to IDLE, where the still-held request completes as a hit.
// Optional feature macro: DCACHE_STATS_EN adds saturating hit/miss counters
// (hit_cnt_o, miss_cnt_o). Without it those ports and counters are absent.
// The parameters must match the package geometry (address slicing uses it).
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   cpu_req_i, cpu_we_i          access request / 1 = store
//   cpu_addr_i, cpu_wdata_i      byte address, store data
//   cpu_rdata_o, cpu_stall_o     load data, pipeline freeze
//   mem_req_o, mem_we_o          line transfer request / 1 = write-back
//   mem_addr_o, mem_wdata_o      line address, victim line
//   mem_ack_i, mem_rdata_i       completion pulse, refill line
//   hit_cnt_o, miss_cnt_o        (DCACHE_STATS_EN only) access statistics
// ----------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int IDX_W  = DC_IDX_W,
  parameter int LINE_W = DC_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  state_t r_state;
  state_t w_nextState;

  logic [TAG_W-1:0]  r_missTag;
  logic [IDX_W-1:0]  r_missIdx;

  addr_fields_t      w_cpuFields;
  logic [1:0]        w_unusedByteOff;
  logic [IDX_W-1:0]  w_arrIdx;
  logic [TAG_W-1:0]  w_rdTag;
  logic              w_rdValid;
  logic              w_rdDirty;
  logic [LINE_W-1:0] w_rdLine;
  logic [31:0]       w_hitWord;
  logic              w_hit;
  logic              w_idleReq;
  logic              w_idleMiss;
  logic              w_wordWe;
  logic              w_lineWe;

  assign w_cpuFields     = splitAddr(cpu_addr_i);
  assign w_unusedByteOff = w_cpuFields.byteOff;

  // Outside IDLE the arrays are addressed by the latched miss index, so the
  // victim line and the refill target do not follow a wandering cpu_addr_i.
  assign w_arrIdx   = (r_state == S_IDLE) ? w_cpuFields.idx : r_missIdx;
  assign w_hit      = w_rdValid && (w_rdTag == w_cpuFields.tag);
  assign w_idleReq  = (r_state == S_IDLE) && cpu_req_i;
  assign w_idleMiss = w_idleReq && !w_hit;
  assign w_wordWe   = w_idleReq && w_hit && cpu_we_i;
  assign w_lineWe   = (r_state == S_RF) && mem_ack_i;
  assign w_hitWord  = w_rdLine[{w_cpuFields.word, 5'b00000} +: 32];

  dcache_sram #(
    .IDX_W    (IDX_W),
    .LINE_W   (LINE_W),
    .TAG_BITS (TAG_W)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_idx      (w_arrIdx),
    .i_lineWe   (w_lineWe),
    .i_lineTag  (r_missTag),
    .i_lineData (mem_rdata_i),
    .i_wordWe   (w_wordWe),
    .i_wordSel  (w_cpuFields.word),
    .i_wordData (cpu_wdata_i),
    .o_tag      (w_rdTag),
    .o_valid    (w_rdValid),
    .o_dirty    (w_rdDirty),
    .o_line     (w_rdLine)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The request is captured only on the IDLE miss cycle; WB and RF work
  // from this copy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_missTag <= '0;
      r_missIdx <= '0;
    end else if (w_idleMiss) begin
      r_missTag <= w_cpuFields.tag;
      r_missIdx <= w_cpuFields.idx;
    end
  end

  // Acks are only acted on in WB/RF, so a stray ack in IDLE is harmless.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_idleMiss) begin
          w_nextState = (w_rdValid && w_rdDirty) ? S_WB : S_RF;
        end
      end
      S_WB: begin
        if (mem_ack_i) begin
          w_nextState = S_RF;
        end
      end
      S_RF: begin
        if (mem_ack_i) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // The victim tag and line are read live from the arrays during WB; nothing
  // writes that line until the refill ack, so they stay stable.
  always_comb begin
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (r_state)
      S_IDLE: begin
        cpu_stall_o = w_idleMiss;
        if (w_idleReq && w_hit && !cpu_we_i) begin
          cpu_rdata_o = w_hitWord;
        end
      end
      S_WB: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = lineAddr(w_rdTag, r_missIdx);
        mem_wdata_o = w_rdLine;
      end
      S_RF: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = lineAddr(r_missTag, r_missIdx);
      end
      default: begin
        cpu_stall_o = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;

  // One count per IDLE resolution; the completing access after a refill is
  // itself an IDLE hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else begin
      if (w_idleReq && w_hit && (r_hitCnt != 32'hFFFF_FFFF)) begin
        r_hitCnt <= r_hitCnt + 32'd1;
      end
      if (w_idleMiss && (r_missCnt != 32'hFFFF_FFFF)) begin
        r_missCnt <= r_missCnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hitCnt;
  assign miss_cnt_o = r_missCnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
